// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite-ROM read port among NREQ
// sprite address generators. Each grant runs a burst of consecutive ROM words.
// Read data comes back tagged one-hot to the requester that owns it.
//
// Optional feature macro: SPRITE_ARB_PLAYER_PRIO_EN. When it is defined,
// requester 0 (the player sprite) always wins arbitration.
//
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_hold          blocks new bursts; a burst already running completes
//   i_req           per-requester level request, held until o_gnt
//   i_req_addr      burst base addresses, requester i in [i*AW +: AW]
//   i_req_len       burst length minus one, requester i in [i*LW +: LW]
//   o_gnt           one-cycle one-hot grant pulse
//   o_busy          high while a burst is being issued
//   o_rom_en        ROM read enable
//   o_rom_addr      ROM read address
//   i_rom_dout      ROM data, valid ROM_LAT cycles after o_rom_en
//   o_rd_valid      one-hot owner of o_rd_data
//   o_rd_data       returned ROM word
//   o_rd_last       final word of a burst
module sprite_rom_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = 14,
    parameter int unsigned DW      = 12,
    parameter int unsigned LW      = 6,
    parameter int unsigned ROM_LAT = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_hold,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*LW-1:0] i_req_len,
    output logic [NREQ-1:0]    o_gnt,
    output logic               o_busy,
    output logic               o_rom_en,
    output logic [AW-1:0]      o_rom_addr,
    input  logic [DW-1:0]      i_rom_dout,
    output logic [NREQ-1:0]    o_rd_valid,
    output logic [DW-1:0]      o_rd_data,
    output logic               o_rd_last
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic [AW-1:0]   r_addr;
    logic [LW-1:0]   r_cnt;
    logic [NREQ-1:0] r_issue_oh;
    logic            r_issue_last;
    logic [NREQ-1:0] r_pipe_vld  [ROM_LAT];
    logic            r_pipe_last [ROM_LAT];

    logic [AW-1:0]   w_addr_arr [NREQ];
    logic [LW-1:0]   w_len_arr  [NREQ];
    logic            w_any;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_idx;

    // Unpack the flat request buses
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr_arr[g] = i_req_addr[g*AW +: AW];
        assign w_len_arr[g]  = i_req_len[g*LW +: LW];
    end

    // Round-robin pick: first set request at or above r_ptr, wrapping
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_idx = IW'((32'(r_ptr) + i) % NREQ);
            if (!w_any && i_req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
        // Player sprite overrides the rotation
        if (i_req[0]) begin
            w_any = 1'b1;
            w_win = '0;
        end
`endif
    end

    // Arbitration FSM, burst issue and return-tag pipeline
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_issue_oh   <= '0;
            r_issue_last <= 1'b0;
            o_gnt        <= '0;
            o_busy       <= 1'b0;
            o_rom_en     <= 1'b0;
            o_rom_addr   <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                r_pipe_vld[i]  <= '0;
                r_pipe_last[i] <= 1'b0;
            end
        end else begin
            o_gnt        <= '0;
            o_rom_en     <= 1'b0;
            r_issue_oh   <= '0;
            r_issue_last <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!i_hold && w_any) begin
                        o_gnt   <= NREQ'(1) << w_win;
                        o_busy  <= 1'b1;
                        r_owner <= w_win;
                        r_addr  <= w_addr_arr[w_win];
                        r_cnt   <= w_len_arr[w_win];
                        r_state <= S_BURST;
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
                        if (w_win != '0) begin
                            r_ptr <= IW'((32'(w_win) + 1) % NREQ);
                        end
`else
                        r_ptr <= IW'((32'(w_win) + 1) % NREQ);
`endif
                    end
                end
                S_BURST: begin
                    // One word per cycle; r_cnt counts the words still to go
                    o_rom_en     <= 1'b1;
                    o_rom_addr   <= r_addr;
                    r_addr       <= r_addr + AW'(1);
                    r_issue_oh   <= NREQ'(1) << r_owner;
                    r_issue_last <= (r_cnt == '0);
                    if (r_cnt == '0) begin
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - LW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Tag travels alongside the read so it lines up with i_rom_dout
            r_pipe_vld[0]  <= r_issue_oh;
            r_pipe_last[0] <= r_issue_last;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
        end
    end

    assign o_rd_valid = r_pipe_vld[ROM_LAT-1];
    assign o_rd_last  = r_pipe_last[ROM_LAT-1];
    // Data comes straight from the ROM output register, zeroed when not owned
    assign o_rd_data  = (|r_pipe_vld[ROM_LAT-1]) ? i_rom_dout : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomised scoreboard bench for sprite_rom_arbiter. A transaction-level
// model predicts grants, ROM reads and returned words with cycle stamps.
module tb_sprite_rom_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 14;
    localparam int unsigned DW   = 12;
    localparam int unsigned LW   = 6;
    localparam int unsigned LAT  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                hold;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*LW-1:0]  req_len;
    logic [NREQ-1:0]     gnt;
    logic                busy;
    logic                rom_en;
    logic [AW-1:0]       rom_addr;
    logic [DW-1:0]       rom_dout;
    logic [NREQ-1:0]     rd_valid;
    logic [DW-1:0]       rd_data;
    logic                rd_last;

    int ra [NREQ];
    int rl [NREQ];

    sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW), .ROM_LAT(LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_req(req),
        .i_req_addr(req_addr), .i_req_len(req_len), .o_gnt(gnt), .o_busy(busy),
        .o_rom_en(rom_en), .o_rom_addr(rom_addr), .i_rom_dout(rom_dout),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_last(rd_last)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = AW'(ra[i]);
            req_len[i*LW +: LW]  = LW'(rl[i]);
        end
    end

    function automatic logic [DW-1:0] rom_f(int a);
        return DW'((a * 13) ^ (a >> 3) ^ 'h5A5);
    endfunction

    // Behavioural ROM with LAT cycles of read latency
    logic [DW-1:0] romq [LAT];
    always @(posedge clk) begin
        romq[0] <= rom_en ? rom_f(int'(rom_addr)) : '0;
        for (int j = 1; j < LAT; j++) romq[j] <= romq[j-1];
    end
    assign rom_dout = romq[LAT-1];

    typedef struct { int cyc; int who; } gev_t;
    typedef struct { int cyc; int addr; } rev_t;
    typedef struct { int cyc; int who; int data; bit last; } dev_t;

    gev_t gq[$];
    rev_t rq[$];
    dev_t dq[$];

    int cyc = 0;
    int m_ptr = 0;
    int m_free = 0;
    int b_start = 1;
    int b_end = 0;
    int checks = 0;
    int errors = 0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: decides at each clock edge using the driven inputs
    always @(posedge clk) begin
        if (rst) begin
            gq.delete(); rq.delete(); dq.delete();
            m_ptr = 0; m_free = cyc + 1; b_start = 1; b_end = 0;
        end else if (cyc >= m_free && !hold && req != '0) begin
            int win;
            bit found;
            win = 0; found = 0;
            for (int j = 0; j < NREQ; j++) begin
                int k;
                k = (m_ptr + j) % NREQ;
                if (!found && req[k]) begin win = k; found = 1; end
            end
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
            if (req[0]) win = 0;
            if (win != 0) m_ptr = (win + 1) % NREQ;
`else
            m_ptr = (win + 1) % NREQ;
`endif
            gq.push_back('{cyc + 1, win});
            for (int k = 0; k <= rl[win]; k++) begin
                int a;
                a = (ra[win] + k) % (1 << AW);
                rq.push_back('{cyc + 2 + k, a});
                dq.push_back('{cyc + 2 + k + LAT, win, int'(rom_f(a)), k == rl[win]});
            end
            m_free  = cyc + rl[win] + 2;
            b_start = cyc + 1;
            b_end   = cyc + 1 + rl[win];
        end
        cyc++;
    end

    // Monitor: compare every output each cycle against the queued expectations
    always @(negedge clk) begin
        logic [NREQ-1:0] eg, ev;
        logic            een, el;
        int              ea, ed;
        if (cyc >= 1) begin
            eg = '0; een = 0; ea = 0; ev = '0; ed = 0; el = 0;
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                eg = NREQ'(1) << gq[0].who; void'(gq.pop_front());
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                een = 1; ea = rq[0].addr; void'(rq.pop_front());
            end
            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                ev = NREQ'(1) << dq[0].who; ed = dq[0].data; el = dq[0].last;
                void'(dq.pop_front());
            end
            check("gnt", 64'(gnt), 64'(eg));
            check("rom_en", 64'(rom_en), 64'(een));
            if (een) check("rom_addr", 64'(rom_addr), 64'(ea));
            check("rd_valid", 64'(rd_valid), 64'(ev));
            check("rd_data", 64'(rd_data), 64'(ed));
            check("rd_last", 64'(rd_last), 64'(el));
            check("busy", 64'(busy), 64'(cyc >= b_start && cyc <= b_end));
        end
    end

    // Stimulus-side observation counters and requester state
    int n_en = 0, n_busy = 0, n_vld = 0;
    int n_vld_r [NREQ];
    bit pend [NREQ];
    bit sticky [NREQ];
    bit rnd_mode = 0;

    task automatic new_req(int i);
        ra[i] = ($urandom_range(0, 5) == 0) ? 'h3FF0 + $urandom_range(0, 15) : int'($urandom_range(0, (1 << AW) - 1));
        rl[i] = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 7));
        req[i] = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        n_en   += int'(rom_en);
        n_busy += int'(busy);
        n_vld  += int'(|rd_valid);
        for (int i = 0; i < NREQ; i++) n_vld_r[i] += int'(rd_valid[i]);
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
                pend[i] = 0;
                if (rnd_mode) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
                    else new_req(i);
                end else if (!sticky[i]) begin
                    req[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) if (gnt[i]) pend[i] = 1;
        if (rnd_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && !req[i] && $urandom_range(0, 7) == 0) new_req(i);
                else if (!pend[i] && req[i] && $urandom_range(0, 49) == 0) req[i] = 1'b0;
            end
            if ($urandom_range(0, 29) == 0) hold = ~hold;
            rst = ($urandom_range(0, 499) == 0);
        end
    endtask

    task automatic wait_idle(string nm, int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(gq.size() == 0 && rq.size() == 0 && dq.size() == 0 &&
                     cyc >= m_free && req == '0) && n < budget);
        if (n >= budget) check({nm, "_timeout"}, 64'(1), 64'(0));
    endtask

    initial begin
        int s_en, s_busy, s_vld, s_v2, n, g0, g3;
        int order[6];
        int seen;
        rst = 1; hold = 0; req = '0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = 0; rl[i] = 0; pend[i] = 0; sticky[i] = 0; n_vld_r[i] = 0;
        end

        // Reset with no requests: everything idle and zero
        repeat (3) step();
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rom_addr", 64'(rom_addr), 64'(0));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        rst = 0;

        // Single burst from requester 2
        s_vld = n_vld_r[2];
        ra[2] = 'h100; rl[2] = 3; req[2] = 1'b1;
        wait_idle("single", 100);
        check("single_words", 64'(n_vld_r[2] - s_vld), 64'(4));

        // Rotation with all requests held, starting from a fresh pointer
        rst = 1; step(); rst = 0;
        for (int i = 0; i < NREQ; i++) begin
            sticky[i] = 1; ra[i] = i * 'h40; rl[i] = 0;
        end
        req = '1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (gnt != '0 && seen < 6) begin
                for (int i = 0; i < NREQ; i++) if (gnt[i]) order[seen] = i;
                seen++;
            end
        end
        for (int i = 0; i < NREQ; i++) sticky[i] = 0;
        req = '0;
        wait_idle("rotate", 100);
        check("rotate_count", 64'(seen), 64'(6));
        for (int i = 0; i < 6; i++) check("rotate_order", 64'(order[i]), 64'(i % NREQ));

        // Address wrap at the top of the ROM
        ra[1] = 'h3FFE; rl[1] = 2; req[1] = 1'b1;
        wait_idle("wrap", 100);

        // Maximum burst length
        s_en = n_en; s_busy = n_busy;
        ra[3] = 'h1234; rl[3] = 63; req[3] = 1'b1;
        wait_idle("maxlen", 200);
        check("maxlen_rom_en", 64'(n_en - s_en), 64'(64));
        check("maxlen_busy", 64'(n_busy - s_busy), 64'(64));

        // Hold raised during word 5 of a 10-word burst
        s_en = n_en; s_vld = n_vld;
        ra[0] = 'h200; rl[0] = 9; req[0] = 1'b1;
        n = 0;
        while (n_en - s_en < 5 && n < 50) begin step(); n++; end
        hold = 1;
        ra[1] = 'h280; rl[1] = 2; req[1] = 1'b1;
        repeat (25) step();
        check("hold_no_gnt", 64'(req[1]), 64'(1));
        hold = 0;
        step();
        check("gnt_after_hold", 64'(gnt), 64'(4'b0010));
        wait_idle("hold", 100);
        check("hold_words", 64'(n_vld - s_vld), 64'(13));

        // Reset after the second word of an 8-word burst
        s_en = n_en;
        ra[2] = 'h300; rl[2] = 7; req[2] = 1'b1;
        n = 0;
        while (n_en - s_en < 2 && n < 50) begin step(); n++; end
        ra[1] = 'h080; rl[1] = 1; req[1] = 1'b1;
        rst = 1;
        s_v2 = n_vld_r[2];
        step();
        rst = 0;
        check("rst_mid_busy", 64'(busy), 64'(0));
        step();
        check("rst_regrant", 64'(gnt), 64'(4'b0010));
        wait_idle("rst_mid", 100);
        check("rst_flushed", 64'(n_vld_r[2] - s_v2), 64'(0));

        // Player sprite against requester 3
        rst = 1; step(); rst = 0;
        g0 = 0; g3 = 0;
        sticky[0] = 1; sticky[3] = 1;
        ra[0] = 'h010; rl[0] = 1; ra[3] = 'h030; rl[3] = 1;
        req[0] = 1'b1; req[3] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            g0 += int'(gnt[0]);
            g3 += int'(gnt[3]);
        end
        sticky[0] = 0; sticky[3] = 0; req = '0;
        wait_idle("prio", 100);
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
        check("prio_g3", 64'(g3), 64'(0));
`else
        check("alt_balance", 64'((g0 - g3 <= 1) && (g3 - g0 <= 1) && g3 > 0), 64'(1));
`endif

        // Randomised traffic with hold and occasional reset
        rnd_mode = 1;
        repeat (3000) step();
        rnd_mode = 0; hold = 0; rst = 0; req = '0;
        for (int i = 0; i < NREQ; i++) sticky[i] = 0;
        wait_idle("random", 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
